// File: rtl/div_seq.sv
// -----------------------------------------------------------------------------
// div_seq -- multi-cycle unsigned restoring divider for the execute stage.
//
// Produces one quotient bit per clock by driving an external, shared,
// purely combinational 64-bit subtractor (sub_a - sub_b -> sub_d, sub_c).
// A request is accepted on start_valid && start_ready. The result is held on
// quotient/remainder/div_by_zero with res_valid until res_valid && res_ready.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   start_valid     request valid
//   start_ready     high only in IDLE
//   dividend        numerator, sampled on accept
//   divisor         denominator, sampled on accept
//   res_valid       result valid (DONE state), held until consumed
//   res_ready       consumer accepts the result
//   quotient        quotient (meaningful while res_valid)
//   remainder       remainder (meaningful while res_valid)
//   div_by_zero     accepted request had divisor == 0
//   busy            high in RUN or DONE
//   sub_a, sub_b    subtractor operands (zero outside RUN)
//   sub_d, sub_c    subtractor difference and carry-out (1 => a >= b)
//
// Latency from the accept edge to res_valid, counting the accept edge as the
// first cycle: 65 cycles for a non-zero divisor, 1 cycle for a zero divisor.
// -----------------------------------------------------------------------------
module div_seq #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy,
  output logic [WIDTH-1:0] sub_a,
  output logic [WIDTH-1:0] sub_b,
  input  logic [WIDTH-1:0] sub_d,
  input  logic             sub_c
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  // q_q holds the not-yet-consumed dividend bits in its upper end and the
  // quotient bits shifted in at its lower end; after WIDTH steps it is the
  // complete quotient.
  logic [WIDTH-1:0] q_q,     q_d;
  logic [WIDTH-1:0] d_q,     d_d;
  logic [WIDTH-1:0] rem_q,   rem_d;
  logic             dbz_q,   dbz_d;

  // Partial remainder shifted left with the next dividend bit brought in.
  logic [WIDTH-1:0] tmp;
  // Bit shifted out of the top of the partial remainder: the true partial
  // remainder is WIDTH+1 bits wide, and when this bit is set it necessarily
  // exceeds the divisor, so the subtraction is forced. The WIDTH-bit sub_d is
  // still exact in that case because the true difference is below 2^WIDTH.
  logic             ovf;
  logic             ge;

  assign tmp = {rem_q[WIDTH-2:0], q_q[WIDTH-1]};
  assign ovf = rem_q[WIDTH-1];
  assign ge  = ovf | sub_c;

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    d_d     = d_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    sub_a   = '0;
    sub_b   = '0;

    case (state_q)
      S_IDLE: begin
        if (start_valid) begin
          d_d   = divisor;
          cnt_d = CNT_LAST;
          if (divisor == '0) begin
            // Divide by zero resolves immediately with the conventional
            // all-ones quotient and the dividend as remainder.
            q_d     = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            q_d     = dividend;
            rem_d   = '0;
            dbz_d   = 1'b0;
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        sub_a = tmp;
        sub_b = d_q;
        rem_d = ge ? sub_d : tmp;
        q_d   = {q_q[WIDTH-2:0], ge};
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_DONE: begin
        // Outputs are registers, so they stay stable while res_ready is low.
        if (res_ready) begin
          dbz_d   = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        // Unused encoding recovers to IDLE.
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      d_q     <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      d_q     <= d_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign start_ready = (state_q == S_IDLE);
  assign res_valid   = (state_q == S_DONE);
  assign busy        = (state_q == S_RUN) || (state_q == S_DONE);
  assign quotient    = q_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_seq.sv
// -----------------------------------------------------------------------------
// tb_div_seq -- directed testbench for div_seq.
// The stimulus process issues requests and pushes hand-computed results into
// a queue; an independent monitor pops and compares on every result
// handshake. A combinational model of the shared subtractor is attached.
// -----------------------------------------------------------------------------
module tb_div_seq;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic         busy;
  logic [W-1:0] sub_a;
  logic [W-1:0] sub_b;
  logic [W-1:0] sub_d;
  logic         sub_c;

  always #5 clk = ~clk;

  // Shared subtractor: a + ~b + 1, carry-out means a >= b.
  logic [W:0] sub_sum;
  assign sub_sum = {1'b0, sub_a} + {1'b0, ~sub_b} + {{W{1'b0}}, 1'b1};
  assign sub_d   = sub_sum[W-1:0];
  assign sub_c   = sub_sum[W];

  div_seq #(.WIDTH(64), .CNT_W(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .busy        (busy),
    .sub_a       (sub_a),
    .sub_b       (sub_b),
    .sub_d       (sub_d),
    .sub_c       (sub_c)
  );

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } exp_t;

  exp_t exp_fifo[$];
  int   total = 0;
  int   bad   = 0;
  int   popped = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Monitor: result handshake sampled on the falling edge, away from the
  // active edge; inputs are driven 1 time unit after the rising edge.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (exp_fifo.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got q=%h r=%h dbz=%0b want none", quotient, remainder, div_by_zero);
      end else begin
        exp_t e;
        e = exp_fifo.pop_front();
        popped++;
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("div_by_zero", {63'd0, div_by_zero}, {63'd0, e.dbz});
        $display("result #%0d: q=%h r=%h dbz=%0b (want q=%h r=%h dbz=%0b)",
                 popped, quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request; hold > 0 keeps res_ready low for that many cycles
  // after res_valid rises, pulsing start_valid meanwhile.
  task automatic do_req(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic edbz, input int exp_lat, input int hold);
    int lat;
    chk("start_ready_before", {63'd0, start_ready}, 64'd1);
    chk("sub_a_idle", sub_a, 64'd0);
    start_valid = 1'b1;
    dividend    = a;
    divisor     = b;
    res_ready   = (hold == 0);
    exp_fifo.push_back('{q: eq, r: er, dbz: edbz});
    tick();  // accept edge
    start_valid = 1'b0;
    // Changing operands after accept must not matter.
    dividend = 64'h0123_4567_89AB_CDEF;
    divisor  = 64'h3;
    lat = 1;
    while (!res_valid && lat < 200) begin
      if (lat == 10) begin
        chk("busy_run", {63'd0, busy}, 64'd1);
        chk("start_ready_run", {63'd0, start_ready}, 64'd0);
      end
      tick();
      lat++;
    end
    chk("latency", 64'(lat), 64'(exp_lat));
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", {63'd0, res_valid}, 64'd1);
      chk("hold_quotient", quotient, eq);
      chk("hold_remainder", remainder, er);
      chk("hold_start_ready", {63'd0, start_ready}, 64'd0);
      start_valid = i[0];
      dividend    = 64'd7;
      divisor     = 64'd1;
      tick();
    end
    start_valid = 1'b0;
    res_ready   = 1'b1;
    tick();  // handshake edge
    chk("res_valid_after", {63'd0, res_valid}, 64'd0);
    chk("start_ready_after", {63'd0, start_ready}, 64'd1);
    chk("dbz_cleared", {63'd0, div_by_zero}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst         = 1'b1;
    start_valid = 1'b0;
    res_ready   = 1'b1;
    dividend    = '0;
    divisor     = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_start_ready", {63'd0, start_ready}, 64'd1);
    chk("rst_res_valid", {63'd0, res_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_dbz", {63'd0, div_by_zero}, 64'd0);
    chk("rst_quotient", quotient, 64'd0);
    chk("rst_remainder", remainder, 64'd0);

    do_req(64'd100, 64'd7, 64'd14, 64'd2, 1'b0, 65, 0);
    do_req(64'd5, 64'd9, 64'd0, 64'd5, 1'b0, 65, 0);
    do_req(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 65, 0);
    do_req(64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
           64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 65, 0);
    do_req(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'd0, 64'h8000_0000_0000_0000, 1'b0, 65, 0);
    do_req(64'd1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1234, 1'b1, 1, 0);
    do_req(64'd1000, 64'd10, 64'd100, 64'd0, 1'b0, 65, 20);

    // Reset in the middle of RUN: the aborted operation is never reported.
    start_valid = 1'b1;
    dividend    = 64'd999;
    divisor     = 64'd4;
    tick();
    start_valid = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    chk("abort_busy", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_start_ready", {63'd0, start_ready}, 64'd1);
    chk("abort_res_valid", {63'd0, res_valid}, 64'd0);
    chk("abort_busy_low", {63'd0, busy}, 64'd0);
    for (int i = 0; i < 70; i++) begin
      if (res_valid) begin
        total++;
        bad++;
        $display("FAIL abort_leak: got res_valid=1 want 0");
      end
      tick();
    end
    do_req(64'd81, 64'd9, 64'd9, 64'd0, 1'b0, 65, 0);

    tick();
    chk("results_consumed", 64'(popped), 64'd8);
    chk("queue_empty", 64'(exp_fifo.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Multi-cycle unsigned 64-bit restoring-division sequencer for the execute stage.
- Drives the shared 64-bit ripple subtractor through its port pair, one quotient bit per cycle.
- Presents a valid/ready request and response handshake to the pipeline control, which stalls on start_ready/res_valid.

Parameters:
- WIDTH, 64, operand/result width; the subtractor is 64-bit, so only 64 is supported.
- CNT_W, 6, iteration counter width, equal to log2(WIDTH).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start_valid  input  1  request valid.
- start_ready  output  1  sequencer can accept a request.
- dividend  input  64  numerator; sampled on accept.
- divisor  input  64  denominator; sampled on accept.
- res_valid  output  1  result valid; held until consumed.
- res_ready  input  1  consumer accepts the result.
- quotient  output  64  quotient.
- remainder  output  64  remainder.
- div_by_zero  output  1  set with res_valid when divisor was 0.
- busy  output  1  high in RUN or DONE.
- sub_a  output  64  subtractor minuend.
- sub_b  output  64  subtractor subtrahend.
- sub_d  input  64  subtractor difference, a - b mod 2^64.
- sub_c  input  1  subtractor carry-out of a + ~b + 1; 1 means a >= b unsigned.

Behaviour:
- Reset: rst=1 at a clock edge forces state IDLE in any state, including mid-RUN or mid-DONE.
  - Reset values: start_ready=1, res_valid=0, div_by_zero=0, busy=0, quotient=0, remainder=0, counter=0.
  - Any in-flight operation is dropped and never reported.
- States: IDLE, RUN, DONE, encoded in 2 bits; the unused encoding goes to IDLE.
- IDLE:
  - start_ready=1; sub_a=sub_b=0.
  - Accept occurs when start_valid && start_ready. On accept, capture q_reg=dividend, d_reg=divisor, rem_reg=0, cnt=63.
  - If divisor==0: go to DONE with quotient=all-ones, remainder=dividend, div_by_zero=1. Latency 1 cycle.
  - Otherwise go to RUN.
- RUN, exactly 64 cycles:
  - Combinational: tmp={rem_reg[62:0], q_reg[63]}; ovf=rem_reg[63]; sub_a=tmp; sub_b=d_reg; ge=ovf | sub_c.
  - On the edge: rem_reg <= ge ? sub_d : tmp; q_reg <= {q_reg[62:0], ge}.
  - ovf covers the 65-bit partial remainder. When set, the subtract is always taken, and the 64-bit sub_d is exact because the true result is < 2^64.
  - If cnt==0, go to DONE; else cnt <= cnt-1.
  - start_ready=0.
- DONE:
  - res_valid=1; quotient=q_reg; remainder=rem_reg; div_by_zero per the accepted request. All outputs stable while res_ready=0.
  - On res_valid && res_ready: go to IDLE and clear res_valid and div_by_zero.
  - start_ready rises the following cycle; there is no same-cycle restart.
- Latency: accept edge to res_valid is 65 cycles for a non-zero divisor and 1 cycle for a zero divisor.
- quotient and remainder are only meaningful while res_valid=1. In IDLE/RUN they reflect internal registers and are not checked.
- start_valid is ignored outside IDLE. Changes to dividend/divisor after accept have no effect.
- sub_d and sub_c are sampled only in RUN; the subtractor is purely combinational, with a single-cycle path.

Test Plan:
- 100/7, res_ready held 1 -> res_valid 65 cycles after accept; quotient=14, remainder=2, div_by_zero=0; start_ready returns 1 the cycle after the handshake.
- 5/9 -> quotient=0, remainder=5. Then 0xFFFFFFFFFFFFFFFF/1 -> quotient=0xFFFFFFFFFFFFFFFF, remainder=0.
- Overflow path: 0xFFFFFFFFFFFFFFFF/0x8000000000000000 -> quotient=1, remainder=0x7FFFFFFFFFFFFFFF. Then 0x8000000000000000/0xFFFFFFFFFFFFFFFF -> quotient=0, remainder=0x8000000000000000.
- 1234/0 -> res_valid 1 cycle after accept; quotient=0xFFFFFFFFFFFFFFFF, remainder=1234, div_by_zero=1.
- Backpressure: 1000/10 with res_ready=0 for 20 cycles after res_valid -> quotient=100, remainder=0 held constant; start_valid pulses ignored; start_ready=0 throughout.
- Reset mid-RUN at cycle 30 -> next cycle IDLE, start_ready=1, res_valid=0. A new request 81/9 yields quotient=9, remainder=0 with no trace of the aborted operation.
